// File: rtl/usb_rx_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : usb_rx_reader                                                     |
// | Brief  : FT601-style synchronous FIFO read master with a first-word        |
// |          fall-through skid buffer presenting words as valid/ready.         |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module usb_rx_reader #(
    parameter int WIDTH       = 32,
    parameter int SKID_DEPTH  = 8,
    parameter int STOP_MARGIN = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     usb_data_in,
    input  logic [WIDTH/8-1:0]   usb_be_in,
    input  logic                 usb_rx_empty,
    output logic                 usb_outen_l,
    output logic                 usb_rden_l,
    input  logic                 rx_allow,
    output logic                 bus_busy,
    output logic [WIDTH-1:0]     out_data,
    output logic [WIDTH/8-1:0]   out_be,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          word_count,
    output logic                 overflow
);

    localparam int c_be_w = WIDTH / 8;
    localparam int c_aw   = $clog2(SKID_DEPTH);
    localparam int c_pw   = c_aw + 1;
    localparam int c_ew   = WIDTH + c_be_w;

    localparam logic [c_pw-1:0] c_depth  = c_pw'(SKID_DEPTH);
    localparam logic [c_pw-1:0] c_margin = c_pw'(STOP_MARGIN);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_turn    = 2'd1;
    localparam logic [1:0] c_st_read    = 2'd2;
    localparam logic [1:0] c_st_release = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_outen_l;
    logic             r_rden_l;
    logic [c_pw-1:0]  r_wr_ptr;
    logic [c_pw-1:0]  r_rd_ptr;
    logic [31:0]      r_word_count;
    logic             r_overflow;
    logic [c_ew-1:0]  r_mem [SKID_DEPTH];

    logic [c_pw-1:0]  w_occ;
    logic [c_pw-1:0]  w_free;
    logic             w_go;
    logic             w_full;
    logic             w_empty;
    logic             w_capture;
    logic             w_push_req;
    logic             w_push;
    logic             w_pop;

    assign w_occ   = r_wr_ptr - r_rd_ptr;
    assign w_free  = c_depth - w_occ;
    assign w_go    = rx_allow & ~usb_rx_empty & (w_free > c_margin);
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                     (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);

    // A word is on the bus only while both strobes are low and the chip has data.
    assign w_capture  = ~r_rden_l & ~r_outen_l & ~usb_rx_empty;
    assign w_push_req = w_capture & (usb_be_in != '0);
    assign w_pop      = ~w_empty & out_ready;
    assign w_push     = w_push_req & (~w_full | w_pop);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:    if (w_go) w_state_nxt = c_st_turn;
            c_st_turn:    w_state_nxt = w_go ? c_st_read : c_st_release;
            c_st_read:    if (!w_go) w_state_nxt = c_st_release;
            c_st_release: w_state_nxt = c_st_idle;
            default:      w_state_nxt = c_st_idle;
        endcase
    end

    // Pin levels are derived from the next state so they change on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_outen_l <= 1'b1;
            r_rden_l  <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_outen_l <= ~((w_state_nxt == c_st_turn) || (w_state_nxt == c_st_read));
            r_rden_l  <= ~(w_state_nxt == c_st_read);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_word_count <= '0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_push_req) begin
                r_word_count <= r_word_count + 32'd1;
            end
            if (w_push_req && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_aw-1:0]] <= {usb_be_in, usb_data_in};
        end
    end

    assign usb_outen_l = r_outen_l;
    assign usb_rden_l  = r_rden_l;
    assign bus_busy    = (r_state != c_st_idle);
    assign out_valid   = ~w_empty;
    assign out_data    = r_mem[r_rd_ptr[c_aw-1:0]][WIDTH-1:0];
    assign out_be      = r_mem[r_rd_ptr[c_aw-1:0]][c_ew-1:WIDTH];
    assign word_count  = r_word_count;
    assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_usb_rx_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_usb_rx_reader                                                  |
// | Brief  : Self-checking bench for usb_rx_reader: USB FIFO source model,     |
// |          per-cycle scoreboard/protocol checker and directed+random tests.  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_usb_rx_reader;

    localparam int DEPTH  = 8;
    localparam int MARGIN = 2;
    localparam int NW     = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] usb_data_in;
    logic [3:0]  usb_be_in;
    logic        usb_rx_empty;
    logic        usb_outen_l;
    logic        usb_rden_l;
    logic        rx_allow = 1'b0;
    logic        bus_busy;
    logic [31:0] out_data;
    logic [3:0]  out_be;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] word_count;
    logic        overflow;

    always #5 clk = ~clk;

    usb_rx_reader #(.WIDTH(32), .SKID_DEPTH(DEPTH), .STOP_MARGIN(MARGIN)) dut (
        .clk(clk), .rst(rst),
        .usb_data_in(usb_data_in), .usb_be_in(usb_be_in), .usb_rx_empty(usb_rx_empty),
        .usb_outen_l(usb_outen_l), .usb_rden_l(usb_rden_l),
        .rx_allow(rx_allow), .bus_busy(bus_busy),
        .out_data(out_data), .out_be(out_be), .out_valid(out_valid), .out_ready(out_ready),
        .word_count(word_count), .overflow(overflow)
    );

    // USB receive FIFO: words advance when the chip sees both strobes low.
    logic [31:0] src_data [NW];
    logic [3:0]  src_be   [NW];
    int          src_wr = 0;
    int          src_rd = 0;
    logic        gap = 1'b0;

    assign usb_rx_empty = (src_rd == src_wr) || gap;
    assign usb_data_in  = src_data[src_rd];
    assign usb_be_in    = src_be[src_rd];

    always @(posedge clk) begin
        if (!usb_rden_l && !usb_outen_l && !usb_rx_empty) src_rd <= src_rd + 1;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: buffer contents as a queue, counts as plain integers.
    logic [35:0] q[$];
    logic [31:0] got[$];
    int          m_count = 0;
    logic        m_ovf   = 1'b0;
    bit          armed   = 1'b0;
    logic        p_rst = 1'b1, p_outen = 1'b1, p_rden = 1'b1, p_busy = 1'b0;
    logic        p_empty = 1'b1, p_allow = 1'b0, p_ready = 1'b0;
    logic [31:0] p_data = '0;
    logic [3:0]  p_be = '0;

    initial forever begin
        bit p_go;
        bit cap;
        @(negedge clk);
        p_go = p_allow && !p_empty && ((DEPTH - q.size()) > MARGIN);
        if (p_rst) begin
            q.delete();
            m_count = 0;
            m_ovf   = 1'b0;
            armed   = 1'b1;
        end else begin
            cap = !p_rden && !p_outen && !p_empty;
            if (p_ready && q.size() != 0) void'(q.pop_front());
            if (cap && p_be != 4'h0) begin
                m_count++;
                if (q.size() < DEPTH) q.push_back({p_be, p_data});
                else m_ovf = 1'b1;
            end
        end
        if (armed) begin
            chk("word_count", 64'(word_count), 64'(m_count));
            chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
            chk("overflow", 64'(overflow), 64'(m_ovf));
            if (q.size() != 0) chk("head", 64'({out_be, out_data}), 64'(q[0]));
            if (!usb_rden_l) chk("rden_needs_outen", 64'(usb_outen_l), 64'd0);
            if (p_rst) begin
                chk("rst_outen", 64'(usb_outen_l), 64'd1);
                chk("rst_rden", 64'(usb_rden_l), 64'd1);
                chk("rst_busy", 64'(bus_busy), 64'd0);
            end else begin
                chk("bus_busy", 64'(bus_busy), 64'(!usb_outen_l || !p_outen));
                if (!p_go) chk("rden_stop", 64'(usb_rden_l), 64'd1);
                if (p_go && !p_outen) chk("rden_go", 64'(usb_rden_l), 64'd0);
                if (!p_go && !p_outen) chk("release_outen", 64'(usb_outen_l), 64'd1);
                if (!p_busy) chk("idle_outen", 64'(usb_outen_l), 64'(!p_go));
                if (p_busy && p_outen) chk("release_one_cycle", 64'(bus_busy), 64'd0);
                if (p_outen && !usb_outen_l) chk("turn_from_idle", 64'(p_busy), 64'd0);
            end
            if (!rst && out_valid && out_ready) got.push_back(out_data);
        end
        p_rst = rst; p_outen = usb_outen_l; p_rden = usb_rden_l; p_busy = bus_busy;
        p_empty = usb_rx_empty; p_allow = rx_allow; p_ready = out_ready;
        p_data = usb_data_in; p_be = usb_be_in;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] d, input logic [3:0] be);
        src_data[src_wr] = d;
        src_be[src_wr]   = be;
        src_wr++;
    endtask

    task automatic wait_drained(input int maxc, input string nm);
        int n = 0;
        while (!(src_rd == src_wr && !bus_busy && !out_valid) && n < maxc) begin
            step();
            n++;
        end
        chk(nm, 64'(n < maxc), 64'd1);
    endtask

    task automatic wait_count(input logic [31:0] target, input int maxc, input string nm);
        int n = 0;
        while (word_count != target && n < maxc) begin
            step();
            n++;
        end
        chk(nm, 64'(n < maxc), 64'd1);
    endtask

    initial begin
        logic [31:0] wc0;
        logic [31:0] exp5 [4];
        #1;
        repeat (5) step();
        chk("reset_outen", 64'(usb_outen_l), 64'd1);
        chk("reset_rden", 64'(usb_rden_l), 64'd1);
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_count", 64'(word_count), 64'd0);
        chk("reset_busy", 64'(bus_busy), 64'd0);
        rst = 1'b0;

        // Eight-word burst, consumer always ready.
        for (int i = 0; i < 8; i++) push_word(32'hA000_0000 + i, 4'hF);
        out_ready = 1'b1;
        rx_allow  = 1'b1;
        wait_drained(200, "burst8_timeout");
        chk("burst8_count", 64'(word_count), 64'd8);
        chk("burst8_ovf", 64'(overflow), 64'd0);
        chk("burst8_n", 64'(got.size()), 64'd8);
        for (int i = 0; i < 8 && i < got.size(); i++) chk("burst8_data", 64'(got[i]), 64'(32'hA000_0000 + i));
        got.delete();

        // Consumer stalled: burst must stop with 6..7 words buffered.
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) push_word(32'hB000_0000 + i, 4'hF);
        repeat (40) step();
        chk("stall_range", 64'((word_count - 32'd8) >= 6 && (word_count - 32'd8) <= 7), 64'd1);
        chk("stall_idle", 64'(bus_busy), 64'd0);
        chk("stall_ovf", 64'(overflow), 64'd0);
        out_ready = 1'b1;
        wait_drained(1000, "stall_timeout");
        chk("stall_count", 64'(word_count), 64'd28);
        chk("stall_n", 64'(got.size()), 64'd20);
        for (int i = 0; i < 20 && i < got.size(); i++) chk("stall_data", 64'(got[i]), 64'(32'hB000_0000 + i));
        got.delete();

        // rx_allow dropped right after the third capture.
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) push_word(32'hC000_0000 + i, 4'hF);
        wait_count(32'd3, 50, "allow_wait");
        rx_allow = 1'b0;
        step();
        chk("allow_rden_high", 64'(usb_rden_l), 64'd1);
        chk("allow_release_busy", 64'(bus_busy), 64'd1);
        step();
        chk("allow_idle", 64'(bus_busy), 64'd0);
        repeat (10) step();
        chk("allow_count", 64'(word_count), 64'd4);
        rx_allow = 1'b1;
        wait_drained(500, "allow_timeout");
        chk("allow_total", 64'(word_count), 64'd10);
        got.delete();

        // A zero byte-enable word is consumed but dropped.
        wc0 = word_count;
        exp5[0] = 32'hD000_0000; exp5[1] = 32'hD000_0001;
        exp5[2] = 32'hD000_0003; exp5[3] = 32'hD000_0004;
        for (int i = 0; i < 5; i++) push_word(32'hD000_0000 + i, (i == 2) ? 4'h0 : 4'hF);
        wait_drained(200, "be0_timeout");
        chk("be0_count", 64'(word_count - wc0), 64'd4);
        chk("be0_n", 64'(got.size()), 64'd4);
        for (int i = 0; i < 4 && i < got.size(); i++) chk("be0_data", 64'(got[i]), 64'(exp5[i]));

        // Reset mid-burst with three words buffered.
        out_ready = 1'b0;
        wc0 = word_count;
        for (int i = 0; i < 10; i++) push_word(32'hE000_0000 + i, 4'hF);
        wait_count(wc0 + 32'd3, 50, "midrst_wait");
        chk("midrst_in_read", 64'(usb_rden_l), 64'd0);
        rst = 1'b1;
        step();
        chk("midrst_outen", 64'(usb_outen_l), 64'd1);
        chk("midrst_rden", 64'(usb_rden_l), 64'd1);
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_count", 64'(word_count), 64'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        wait_drained(500, "midrst_timeout");

        // Randomised traffic checked cycle by cycle against the model.
        for (int i = 0; i < 300; i++)
            push_word($urandom, ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15)));
        for (int c = 0; c < 2500; c++) begin
            rx_allow  = ($urandom_range(0, 9) < 8);
            out_ready = ($urandom_range(0, 9) < 6);
            gap       = ($urandom_range(0, 9) < 2);
            step();
        end
        rx_allow  = 1'b1;
        out_ready = 1'b1;
        gap       = 1'b0;
        wait_drained(2000, "random_timeout");
        chk("random_ovf", 64'(overflow), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got %0d of %0d checks", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
